// File: rtl/esp_prog_bridge.sv
// ESP32 auto-programming and multiboot bridge: synchronises FTDI DTR/RTS and buttons,
// drives ESP32 EN/GPIO0, times the SD_D0 override window and requests the next bitstream.
module esp_prog_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RELEASE_W   = 18,
    parameter int unsigned HOLD_W      = 8,
    parameter bit          STICKY_MB   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dtr_ni,
    input  logic       rts_ni,
    input  logic       btn_hold_ni,
    input  logic       btn_mb_i,
    output logic       esp_en_o,
    output logic       esp_gpio0_o,
    output logic       sd_d0_oe_o,
    output logic       sd_d0_o,
    output logic       prog_active_o,
    output logic       user_programn_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StProg    = 2'd1,
        StRelease = 2'd2
    } state_e;

    localparam logic [HOLD_W-1:0] HoldTop = {1'b1, {(HOLD_W-1){1'b0}}};

    logic [SYNC_STAGES-1:0] dtr_sync_q, rts_sync_q, hold_sync_q, mb_sync_q;
    logic                   d, r, h, m;
    logic                   en_dec, g_dec, entry, chord, fire;
    logic [1:0]             prev_dr_q;
    state_e                 state_q, state_d;
    logic [RELEASE_W-1:0]   timer_q, timer_d, timer_inc;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   en_q, gpio0_q, sd_d0_q, oe_q, active_q, programn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dtr_sync_q  <= '1;
            rts_sync_q  <= '1;
            hold_sync_q <= '1;
            mb_sync_q   <= '0;
        end else begin
            dtr_sync_q  <= {dtr_sync_q[SYNC_STAGES-2:0], dtr_ni};
            rts_sync_q  <= {rts_sync_q[SYNC_STAGES-2:0], rts_ni};
            hold_sync_q <= {hold_sync_q[SYNC_STAGES-2:0], btn_hold_ni};
            mb_sync_q   <= {mb_sync_q[SYNC_STAGES-2:0], btn_mb_i};
        end
    end

    assign d = dtr_sync_q[SYNC_STAGES-1];
    assign r = rts_sync_q[SYNC_STAGES-1];
    assign h = hold_sync_q[SYNC_STAGES-1];
    assign m = mb_sync_q[SYNC_STAGES-1];

    // Only 10 pulls EN low and only 01 pulls GPIO0 low; 00/11 leave the ESP running.
    assign en_dec = ~(d & ~r);
    assign g_dec  = ~(~d & r);
    assign entry  = d & ~r & (prev_dr_q == 2'b11);
    assign chord  = ~h & m;
    assign fire   = chord & (hold_q == HoldTop);

    assign timer_inc = timer_q + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                if (entry) state_d = StProg;
            end
            StProg: begin
                if (en_dec) begin
                    state_d = StRelease;
                    timer_d = '0;
                end
            end
            StRelease: begin
                if (entry) begin
                    state_d = StProg;
                end else if (timer_inc == '1) begin
                    // Leaving as the timer reaches all-ones gives a 2^RELEASE_W-1 cycle window.
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        hold_d = hold_q;
        if (!chord) begin
            hold_d = '0;
        end else if (hold_q != HoldTop) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_dr_q  <= 2'b11;
            state_q    <= StIdle;
            timer_q    <= '0;
            hold_q     <= '0;
            en_q       <= 1'b1;
            gpio0_q    <= 1'b1;
            sd_d0_q    <= 1'b1;
            oe_q       <= 1'b0;
            active_q   <= 1'b0;
            programn_q <= 1'b1;
        end else begin
            prev_dr_q  <= {d, r};
            state_q    <= state_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            en_q       <= en_dec;
            gpio0_q    <= g_dec & h;
            sd_d0_q    <= g_dec;
            oe_q       <= (state_d != StIdle);
            active_q   <= (state_d != StIdle);
            if (STICKY_MB) begin
                programn_q <= programn_q & ~fire;
            end else begin
                programn_q <= ~fire;
            end
        end
    end

    assign esp_en_o        = en_q;
    assign esp_gpio0_o     = gpio0_q;
    assign sd_d0_oe_o      = oe_q;
    assign sd_d0_o         = sd_d0_q;
    assign prog_active_o   = active_q;
    assign user_programn_o = programn_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_esp_prog_bridge.sv
// Randomised scoreboard bench for esp_prog_bridge: a cycle-level reference model queues
// expected outputs, and a negedge monitor compares both sticky and non-sticky instances.
module tb_esp_prog_bridge;

    localparam int unsigned SYNC = 2;
    localparam int unsigned RW   = 4;
    localparam int unsigned HW   = 4;

    typedef struct packed {
        logic d;
        logic r;
        logic h;
        logic m;
    } in_t;

    typedef struct packed {
        logic [7:0] sticky;
        logic [7:0] nosticky;
    } exp_t;

    logic       clk, rst;
    logic       dtr_ni, rts_ni, btn_hold_ni, btn_mb_i;
    logic       en_a, g0_a, oe_a, sd_a, act_a, pn_a;
    logic [1:0] st_a;
    logic       en_b, g0_b, oe_b, sd_b, act_b, pn_b;
    logic [1:0] st_b;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    exp_t exp_q[$];

    // Reference model state
    in_t        pipe[$];
    logic [1:0] m_prev;
    int         m_state;
    int         m_left;
    int         m_run;
    logic       m_pn_s, m_pn_ns, m_en, m_g0, m_sd;

    esp_prog_bridge #(
        .SYNC_STAGES(SYNC), .RELEASE_W(RW), .HOLD_W(HW), .STICKY_MB(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .dtr_ni(dtr_ni), .rts_ni(rts_ni),
        .btn_hold_ni(btn_hold_ni), .btn_mb_i(btn_mb_i),
        .esp_en_o(en_a), .esp_gpio0_o(g0_a), .sd_d0_oe_o(oe_a), .sd_d0_o(sd_a),
        .prog_active_o(act_a), .user_programn_o(pn_a), .state_o(st_a)
    );

    esp_prog_bridge #(
        .SYNC_STAGES(SYNC), .RELEASE_W(RW), .HOLD_W(HW), .STICKY_MB(1'b0)
    ) u_dut_ns (
        .clk(clk), .rst(rst), .dtr_ni(dtr_ni), .rts_ni(rts_ni),
        .btn_hold_ni(btn_hold_ni), .btn_mb_i(btn_mb_i),
        .esp_en_o(en_b), .esp_gpio0_o(g0_b), .sd_d0_oe_o(oe_b), .sd_d0_o(sd_b),
        .prog_active_o(act_b), .user_programn_o(pn_b), .state_o(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pack_out(input logic en, input logic g0, input int st,
                                            input logic sd, input logic pn);
        logic [1:0] s2;
        s2 = 2'(st);
        return {en, g0, (st != 0), sd, (st != 0), pn, s2};
    endfunction

    task automatic model_reset();
        in_t idle_in;
        idle_in = '{d: 1'b1, r: 1'b1, h: 1'b1, m: 1'b0};
        pipe = {};
        for (int i = 0; i < SYNC; i++) pipe.push_back(idle_in);
        m_prev  = 2'b11;
        m_state = 0;
        m_left  = 0;
        m_run   = 0;
        m_pn_s  = 1'b1;
        m_pn_ns = 1'b1;
        m_en    = 1'b1;
        m_g0    = 1'b1;
        m_sd    = 1'b1;
    endtask

    // One clock edge of the reference: pipe[0] is what the last synchroniser stage holds.
    task automatic model_edge();
        in_t  s, cur;
        logic entry, en, g, chord, fire;
        exp_t e;
        if (rst) begin
            model_reset();
        end else begin
            s     = pipe[0];
            entry = s.d && !s.r && (m_prev == 2'b11);
            en    = !(s.d && !s.r);
            g     = !(!s.d && s.r);
            case (m_state)
                0: if (entry) m_state = 1;
                1: if (en) begin
                    m_state = 2;
                    m_left  = (1 << RW) - 1;
                end
                default: begin
                    if (entry) begin
                        m_state = 1;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_state = 0;
                    end
                end
            endcase
            chord = !s.h && s.m;
            fire  = chord && (m_run >= (1 << (HW - 1)));
            if (fire) m_pn_s = 1'b0;
            m_pn_ns = !fire;
            m_run   = chord ? m_run + 1 : 0;
            m_en    = en;
            m_g0    = g && s.h;
            m_sd    = g;
            m_prev  = {s.d, s.r};
            cur     = '{d: dtr_ni, r: rts_ni, h: btn_hold_ni, m: btn_mb_i};
            void'(pipe.pop_front());
            pipe.push_back(cur);
        end
        e.sticky   = pack_out(m_en, m_g0, m_state, m_sd, m_pn_s);
        e.nosticky = pack_out(m_en, m_g0, m_state, m_sd, m_pn_ns);
        exp_q.push_back(e);
    endtask

    task automatic compare(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL cycle %0d %s {en,g0,oe,sd,act,pn,state} got %b required %b",
                     cycle, name, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare("sticky", {en_a, g0_a, oe_a, sd_a, act_a, pn_a, st_a}, e.sticky);
            compare("nosticky", {en_b, g0_b, oe_b, sd_b, act_b, pn_b, st_b}, e.nosticky);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply(input logic [1:0] dr, input logic h, input logic mb, input int n);
        dtr_ni      = dr[1];
        rts_ni      = dr[0];
        btn_hold_ni = h;
        btn_mb_i    = mb;
        repeat (n) tick();
    endtask

    // Reset between clock edges must clear every output before the next edge.
    task automatic async_reset();
        logic [7:0] rst_vec;
        rst_vec = 8'b1101_0100;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare("async_rst_sticky", {en_a, g0_a, oe_a, sd_a, act_a, pn_a, st_a}, rst_vec);
        compare("async_rst_nosticky", {en_b, g0_b, oe_b, sd_b, act_b, pn_b, st_b}, rst_vec);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] dr;
        logic       h, mb;
        int         n;
        rst = 1'b1;
        model_reset();
        apply(2'b11, 1'b1, 1'b0, 3);
        rst = 1'b0;
        apply(2'b11, 1'b1, 1'b0, 4);
        // Programming entry and full release window
        apply(2'b10, 1'b1, 1'b0, 5);
        apply(2'b01, 1'b1, 1'b0, 5);
        apply(2'b11, 1'b1, 1'b0, 25);
        // Retrigger inside the release window
        apply(2'b10, 1'b1, 1'b0, 5);
        apply(2'b11, 1'b1, 1'b0, 10);
        apply(2'b10, 1'b1, 1'b0, 5);
        apply(2'b11, 1'b1, 1'b0, 25);
        // Hold button alone
        apply(2'b11, 1'b0, 1'b0, 10);
        apply(2'b11, 1'b1, 1'b0, 5);
        // Multiboot chord: long enough, then too short
        apply(2'b11, 1'b0, 1'b1, 12);
        apply(2'b11, 1'b1, 1'b0, 8);
        apply(2'b11, 1'b0, 1'b1, 5);
        apply(2'b11, 1'b1, 1'b0, 5);
        // Reset during release with sticky request low
        apply(2'b10, 1'b1, 1'b0, 4);
        apply(2'b11, 1'b1, 1'b0, 6);
        async_reset();
        apply(2'b11, 1'b1, 1'b0, 5);
        // Random segments
        for (int i = 0; i < 200; i++) begin
            dr = 2'($urandom_range(0, 3));
            h  = ($urandom_range(0, 3) != 0);
            mb = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 20);
            apply(dr, h, mb, n);
            if ($urandom_range(0, 39) == 0) async_reset();
        end
        apply(2'b11, 1'b1, 1'b0, 3);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/esp_prog_bridge.md
Name: esp_prog_bridge

Overview:
Parametrised ESP32 auto-programming and multiboot controller for the ULX3S board wrapper. It synchronises the FTDI DTR/RTS lines and decodes them into ESP32 EN/GPIO0 drive. A state machine times the SD_D0 (ESP GPIO2) override window after a programming entry. A debounced button chord requests the next multiboot image through user_programn. Registered outputs and a configurable synchroniser depth replace the purely combinational decode of the earlier wrapper logic.

Parameters:
SYNC_STAGES, 2, flop depth of every input synchroniser (min 2)
RELEASE_W, 18, width of the release timer; the window lasts 2^RELEASE_W - 1 cycles
HOLD_W, 8, width of the multiboot hold counter; the request fires when the counter reaches 2^(HOLD_W-1)
STICKY_MB, 1, 1 = user_programn_o stays low until rst; 0 = low only while the chord is held

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
dtr_ni  in  1  FTDI nDTR, async
rts_ni  in  1  FTDI nRTS, async
btn_hold_ni  in  1  active-low button; low forces GPIO0 low; async
btn_mb_i  in  1  active-high multiboot chord button; async
esp_en_o  out  1  ESP32 EN drive
esp_gpio0_o  out  1  ESP32 GPIO0 drive
sd_d0_oe_o  out  1  output enable for SD_D0 / ESP GPIO2
sd_d0_o  out  1  SD_D0 drive value when enabled
prog_active_o  out  1  high while the FSM is in PROG or RELEASE (LED)
user_programn_o  out  1  low requests the next multiboot image
state_o  out  2  FSM state code, for debug and LED

Behaviour:
- Reset values:
  - all synchroniser flops: 1 for the dtr, rts and btn_hold paths; 0 for btn_mb.
  - outputs: esp_en_o=1, esp_gpio0_o=1, sd_d0_oe_o=0, sd_d0_o=1, prog_active_o=0, user_programn_o=1, state_o=IDLE (2'd0).
  - timer and hold counter: 0.
- Synchronisers: each async input passes through SYNC_STAGES flops. Decode and FSM logic use only the synchronised values (d, r, h, m).
- Decode, registered one cycle after the sync output, so total input-to-output latency = SYNC_STAGES+1 cycles:
  - {d,r}=2'b10 -> en=0, g=1
  - {d,r}=2'b01 -> en=1, g=0
  - 00 or 11 -> en=1, g=1
- Output drives:
  - esp_en_o = en.
  - esp_gpio0_o = g & h.
  - sd_d0_o = g.
- FSM states: IDLE=0, PROG=1, RELEASE=2. Code 3 is unreachable and returns to IDLE.
  - IDLE -> PROG when the decode is en=0 and the previous-cycle {d,r}=11 (entry edge).
  - PROG -> RELEASE on the first cycle with en=1. The timer loads 0 on this transition.
  - RELEASE: the timer increments by 1 per cycle. When the timer equals all-ones, go to IDLE and clear the timer.
  - RELEASE -> PROG on a new entry edge. This retrigger abandons the current window; the timer restarts from 0 on the next PROG->RELEASE.
  - In PROG, further entry edges have no effect.
- Output enables by state:
  - sd_d0_oe_o = 1 in PROG and RELEASE, 0 in IDLE.
  - prog_active_o = (state != IDLE).
  - state_o = state.
- Multiboot:
  - Chord = (h==0) && (m==1).
  - While the chord is true, the hold counter increments and saturates at 2^(HOLD_W-1); it does not wrap.
  - When the chord is false, the counter clears to 0.
  - When the counter reaches 2^(HOLD_W-1), user_programn_o goes low on the next cycle.
  - STICKY_MB=1: user_programn_o stays low until rst. STICKY_MB=0: it returns to 1 the cycle after the chord drops.
- Simultaneous events:
  - A chord during PROG or RELEASE is independent of the FSM. GPIO0 is still forced low by h.
  - A decode of 01 (GPIO0 low, EN high) never triggers PROG.
- Reset mid-operation: rst asserted in any state immediately (asynchronously) returns every output to its reset value, including a sticky user_programn_o.

Test Plan:
- Power-on: rst=1 for 3 cycles, inputs idle (dtr=rts=1, btn_hold=1, btn_mb=0) -> esp_en_o=1, esp_gpio0_o=1, sd_d0_oe_o=0, user_programn_o=1, state_o=0.
- Programming entry (SYNC_STAGES=2, RELEASE_W=4): {dtr,rts} 11->10 for 5 cycles, then 01 for 5 cycles, then 11 -> esp_en_o=0 exactly 3 cycles after the 10 edge, state_o=1, sd_d0_oe_o=1. After en returns to 1: state_o=2, oe held for 15 cycles, then state_o=0 and oe=0.
- Retrigger: during RELEASE at timer=7, apply 11->10 -> state_o=1, and a full 15-cycle window follows the next release.
- Hold button: btn_hold_ni=0 with {dtr,rts}=11 -> esp_gpio0_o=0 after 3 cycles, esp_en_o=1, state_o stays 0.
- Multiboot (HOLD_W=4, STICKY_MB=1): btn_hold_ni=0 and btn_mb_i=1 held for 12 cycles -> user_programn_o=0 at sync+8+1 cycles and stays 0 after release. With STICKY_MB=0, it returns to 1 after release. Chord for only 5 cycles -> no assertion, counter back to 0.
- Async reset mid-RELEASE with user_programn_o=0: assert rst between clock edges -> all outputs at reset values before the next edge.
